sysbus_mem_responder: RTL and testbench

- Memory-side responder for the system bus that the cache drives as initiator on its m_bus_* port.
- Accepts line-granular read and write requests and serves 512-bit lines as 8 beats of 64 bits from an internal line-organised backing store.
- Used as the DRAM model behind the cache in simulation and as the template for the real memory-controller front end.

---
 rtl/sysbus_pkg.sv | 34 +++
 rtl/sysbus_mem_array.sv | 33 +++
 rtl/sysbus_mem_responder.sv | 209 ++++++++++++++++++++
 tb/tb_sysbus_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// ============================================================================
// Module   : sysbus_pkg
// Purpose  : System-bus constants and responder state encoding, shared with the cache.
//            The optional INV state exists only when SYSBUS_SNOOP_INV_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sysbus_pkg;

    localparam logic        SYSBUS_WRITE   = 1'b1;
    localparam logic [12:0] INVAL_TAG      = 13'h0800;
    localparam int          BEATS_PER_LINE = 8;
    localparam int          LINE_BITS      = 512;
    localparam int          LINE_OFFSET    = 6;
    localparam int          BEAT_W         = $clog2(BEATS_PER_LINE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_DONE = 3'd3,
        ST_RD_WAIT = 3'd4,
`ifdef SYSBUS_SNOOP_INV_EN
        ST_RD_RESP = 3'd5,
        ST_INV     = 3'd6
`else
        ST_RD_RESP = 3'd5
`endif
    } resp_state_e;

endpackage

`default_nettype wire

// File: rtl/sysbus_mem_array.sv
// ============================================================================
// Module   : sysbus_mem_array
// Purpose  : Line-organised backing store: synchronous full-line write port,
//            combinational line read port, no reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sysbus_mem_array #(
    parameter int LINE_W    = 512,
    parameter int MEM_LINES = 64
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_LINES)-1:0] wr_idx,
    input  logic [LINE_W-1:0]            wr_line,
    input  logic [$clog2(MEM_LINES)-1:0] rd_idx,
    output logic [LINE_W-1:0]            rd_line
);

    logic [LINE_W-1:0] r_mem [MEM_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_line;
        end
    end

    assign rd_line = r_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
// ============================================================================
// Module   : sysbus_mem_responder
// Purpose  : Memory-side system-bus responder serving 512-bit lines as 8 beats.
//            Define SYSBUS_SNOOP_INV_EN to emit an invalidate beat after each write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_LINES      = 64,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int                LINE_W    = BEATS_PER_LINE * BUS_DATA_WIDTH;
    localparam int                IDX_W     = $clog2(MEM_LINES);
    localparam int                LAT_W     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_LINE - 1);

    resp_state_e               r_state, w_nxt_state;
    logic                      r_reqack, w_nxt_reqack;
    logic [BEAT_W-1:0]         r_beat, w_nxt_beat;
    logic [LAT_W-1:0]          r_lat, w_nxt_lat;
    logic [IDX_W-1:0]          r_idx, w_nxt_idx;
    logic [BUS_TAG_WIDTH-1:0]  r_tag, w_nxt_tag;
    logic [LINE_W-1:0]         r_line_buf, w_nxt_buf;
    logic                      r_respcyc, w_nxt_respcyc;
    logic [BUS_DATA_WIDTH-1:0] r_resp, w_nxt_resp;
    logic [BUS_TAG_WIDTH-1:0]  r_resptag, w_nxt_resptag;
    logic                      w_wr_en;
    logic                      w_req_acc;
    logic [LINE_W-1:0]         w_rd_line;
`ifdef SYSBUS_SNOOP_INV_EN
    localparam int             AHI_W = BUS_DATA_WIDTH - LINE_OFFSET;
    logic [AHI_W-1:0]          r_addr_hi, w_nxt_addr_hi;
`endif

    sysbus_mem_array #(
        .LINE_W    (LINE_W),
        .MEM_LINES (MEM_LINES)
    ) u_mem_array (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_idx  (r_idx),
        .wr_line (w_nxt_buf),
        .rd_idx  (r_idx),
        .rd_line (w_rd_line)
    );

    assign w_req_acc = bus_reqcyc && !r_reqack;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_reqack  = 1'b0;
        w_nxt_beat    = r_beat;
        w_nxt_lat     = r_lat;
        w_nxt_idx     = r_idx;
        w_nxt_tag     = r_tag;
        w_nxt_buf     = r_line_buf;
        w_nxt_respcyc = r_respcyc;
        w_nxt_resp    = r_resp;
        w_nxt_resptag = r_resptag;
        w_wr_en       = 1'b0;
`ifdef SYSBUS_SNOOP_INV_EN
        w_nxt_addr_hi = r_addr_hi;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_req_acc) begin
                    w_nxt_idx    = bus_req[LINE_OFFSET +: IDX_W];
                    w_nxt_tag    = bus_reqtag;
                    w_nxt_reqack = 1'b1;
                    w_nxt_state  = ST_ACK;
`ifdef SYSBUS_SNOOP_INV_EN
                    w_nxt_addr_hi = bus_req[BUS_DATA_WIDTH-1:LINE_OFFSET];
`endif
                end
            end
            ST_ACK: begin
                if (r_tag[BUS_TAG_WIDTH-1] == SYSBUS_WRITE) begin
                    w_nxt_beat  = '0;
                    w_nxt_state = ST_WR_DATA;
                end else begin
                    w_nxt_lat   = LAT_W'(READ_LATENCY - 1);
                    w_nxt_state = ST_RD_WAIT;
                end
            end
            ST_WR_DATA: begin
                if (w_req_acc) begin
                    w_nxt_buf[r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_req;
                    w_nxt_reqack = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        // Array is fed w_nxt_buf so the final beat lands in the same commit.
                        w_wr_en     = 1'b1;
                        w_nxt_beat  = '0;
                        w_nxt_state = ST_WR_DONE;
                    end else begin
                        w_nxt_beat = r_beat + 1'b1;
                    end
                end
            end
            ST_WR_DONE: begin
`ifdef SYSBUS_SNOOP_INV_EN
                w_nxt_respcyc = 1'b1;
                w_nxt_resp    = {r_addr_hi, {LINE_OFFSET{1'b0}}};
                w_nxt_resptag = BUS_TAG_WIDTH'(INVAL_TAG);
                w_nxt_state   = ST_INV;
`else
                w_nxt_state   = ST_IDLE;
`endif
            end
`ifdef SYSBUS_SNOOP_INV_EN
            ST_INV: begin
                if (bus_respack) begin
                    w_nxt_respcyc = 1'b0;
                    w_nxt_resp    = '0;
                    w_nxt_resptag = '0;
                    w_nxt_state   = ST_IDLE;
                end
            end
`endif
            ST_RD_WAIT: begin
                if (r_lat == '0) begin
                    w_nxt_beat    = '0;
                    w_nxt_respcyc = 1'b1;
                    w_nxt_resp    = w_rd_line[0 +: BUS_DATA_WIDTH];
                    w_nxt_resptag = r_tag;
                    w_nxt_state   = ST_RD_RESP;
                end else begin
                    w_nxt_lat = r_lat - 1'b1;
                end
            end
            ST_RD_RESP: begin
                if (bus_respack) begin
                    if (r_beat == LAST_BEAT) begin
                        w_nxt_beat    = '0;
                        w_nxt_respcyc = 1'b0;
                        w_nxt_resp    = '0;
                        w_nxt_resptag = '0;
                        w_nxt_state   = ST_IDLE;
                    end else begin
                        w_nxt_beat = r_beat + 1'b1;
                        w_nxt_resp = w_rd_line[(r_beat + 1'b1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    end
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_reqack  <= 1'b0;
            r_beat    <= '0;
            r_lat     <= '0;
            r_idx     <= '0;
            r_tag     <= '0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
            r_resptag <= '0;
`ifdef SYSBUS_SNOOP_INV_EN
            r_addr_hi <= '0;
`endif
        end else begin
            r_state   <= w_nxt_state;
            r_reqack  <= w_nxt_reqack;
            r_beat    <= w_nxt_beat;
            r_lat     <= w_nxt_lat;
            r_idx     <= w_nxt_idx;
            r_tag     <= w_nxt_tag;
            r_respcyc <= w_nxt_respcyc;
            r_resp    <= w_nxt_resp;
            r_resptag <= w_nxt_resptag;
`ifdef SYSBUS_SNOOP_INV_EN
            r_addr_hi <= w_nxt_addr_hi;
`endif
        end
    end

    // Staging buffer carries no state worth resetting; a partial line is never committed.
    always_ff @(posedge clk) begin
        r_line_buf <= w_nxt_buf;
    end

    assign bus_reqack  = r_reqack;
    assign bus_respcyc = r_respcyc;
    assign bus_resp    = r_resp;
    assign bus_resptag = r_resptag;

endmodule

`default_nettype wire

// File: tb/tb_sysbus_mem_responder.sv
// ============================================================================
// Module   : tb_sysbus_mem_responder
// Purpose  : Self-checking bench for sysbus_mem_responder (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sysbus_mem_responder;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int ML = 64;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bus_reqcyc = 1'b0;
    logic          bus_reqack;
    logic [DW-1:0] bus_req = '0;
    logic [TW-1:0] bus_reqtag = '0;
    logic          bus_respcyc;
    logic          bus_respack = 1'b0;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_LINES      (ML),
        .READ_LATENCY   (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
    } beat_t;

    typedef struct {
        bit          do_wr;
        logic [63:0] waddr;
        logic [12:0] wtag;
        logic [31:0] seed;
        logic [63:0] raddr;
        logic [12:0] rtag;
        int          exp_idx;
        int          stall_beat;
        int          stall_len;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    beat_t        exp_q[$];
    logic [511:0] model [ML];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pattern(input logic [31:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) begin
            if (seed == 32'd0) l[k*64 +: 64] = 64'(32'h11 * (k + 1));
            else               l[k*64 +: 64] = {seed + 32'(k), ~seed ^ 32'(k)};
        end
        return l;
    endfunction

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_reqack && n < 100);
        chk(name, 64'(bus_reqack), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input logic [511:0] line,
                            input int stall_after, input int stall_len, input int abort_at);
        bus_req    = addr;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        wait_ack("wr_addr_ack");
        for (int b = 0; b < 8; b++) begin
            bus_req    = line[b*64 +: 64];
            bus_reqcyc = 1'b1;
            wait_ack("wr_beat_ack");
            if (b == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_reqack", 64'(bus_reqack), 64'd0);
                chk("abort_respcyc", 64'(bus_respcyc), 64'd0);
                chk("abort_resp", bus_resp, 64'd0);
                chk("abort_resptag", 64'(bus_resptag), 64'd0);
                bus_reqcyc = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (b == stall_after) begin
                bus_reqcyc = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_no_ack", 64'(bus_reqack), 64'd0);
                end
            end
        end
        bus_reqcyc = 1'b0;
        model[int'(addr[11:6])] = line;
`ifdef SYSBUS_SNOOP_INV_EN
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus_respcyc && n < 20);
            chk("inv_valid", 64'(bus_respcyc), 64'd1);
            chk("inv_addr", bus_resp, {addr[63:6], 6'b0});
            chk("inv_tag", 64'(bus_resptag), 64'h0800);
            repeat (3) begin
                @(negedge clk);
                chk("inv_hold", bus_resp, {addr[63:6], 6'b0});
            end
            bus_respack = 1'b1;
            @(negedge clk);
            bus_respack = 1'b0;
            chk("inv_end", 64'(bus_respcyc), 64'd0);
        end
`endif
    endtask

    task automatic send_read(input logic [63:0] addr, input logic [12:0] tag, input int idx);
        for (int k = 0; k < 8; k++) exp_q.push_back('{model[idx][k*64 +: 64], tag});
        bus_req    = addr;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        wait_ack("rd_addr_ack");
        bus_reqcyc = 1'b0;
    endtask

    // Entered at the negedge of the ACK cycle; returns at the first negedge after the burst.
    task automatic collect(input int stall_beat, input int stall_len, input bit busy,
                           input logic [63:0] addr2, input logic [12:0] tag2, input int idx2);
        int    n = 0;
        beat_t e;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_respcyc && n < 60);
        chk("rd_latency", 64'(n), 64'(RL + 1));
        if (busy) begin
            for (int k = 0; k < 8; k++) exp_q.push_back('{model[idx2][k*64 +: 64], tag2});
            bus_req    = addr2;
            bus_reqtag = tag2;
            bus_reqcyc = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            if (exp_q.size() == 0) e = '{64'hDEAD, 13'h1FFF};
            else                   e = exp_q.pop_front();
            chk("rd_valid", 64'(bus_respcyc), 64'd1);
            chk("rd_data", bus_resp, e.data);
            chk("rd_tag", 64'(bus_resptag), 64'(e.tag));
            if (busy) chk("busy_no_ack", 64'(bus_reqack), 64'd0);
            if (k == stall_beat) begin
                bus_respack = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("bp_hold", bus_resp, e.data);
                    chk("bp_valid", 64'(bus_respcyc), 64'd1);
                end
            end
            bus_respack = 1'b1;
            @(negedge clk);
        end
        bus_respack = 1'b0;
        chk("rd_end_respcyc", 64'(bus_respcyc), 64'd0);
        chk("rd_end_resp", bus_resp, 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 64'h40,       13'h1005, 32'h0,         64'h40,  13'h0005, 1,  3,  5};
        vecs[1] = '{1'b1, 64'h1040,     13'h1ABC, 32'hA5A5_0001, 64'h40,  13'h0ABC, 1,  -1, 0};
        vecs[2] = '{1'b1, 64'h80,       13'h1001, 32'h0BAD_F00D, 64'hBF,  13'h0FFF, 2,  0,  2};
        vecs[3] = '{1'b1, 64'hFC0,      13'h1FFF, 32'h1357_9BDF, 64'hFFFF_FFFF_FFFF_FFC0, 13'h0000, 63, 7, 3};
        vecs[4] = '{1'b0, 64'h0,        13'h0,    32'h0,         64'h7F,  13'h0042, 1,  -1, 0};
        vecs[5] = '{1'b1, 64'h1234_5678, 13'h1333, 32'h7777_0005, 64'h640, 13'h0333, 25, 4, 1};

        #2 reset = 1'b0;
        #2;
        chk("reset_reqack", 64'(bus_reqack), 64'd0);
        chk("reset_respcyc", 64'(bus_respcyc), 64'd0);
        chk("reset_resp", bus_resp, 64'd0);
        chk("reset_resptag", 64'(bus_resptag), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) do_write(vecs[i].waddr, vecs[i].wtag, pattern(vecs[i].seed), -1, 0, -1);
            send_read(vecs[i].raddr, vecs[i].rtag, vecs[i].exp_idx);
            collect(vecs[i].stall_beat, vecs[i].stall_len, 1'b0, 64'h0, 13'h0, 0);
        end

        // Write stalled for 10 cycles after beat 2, then read back.
        do_write(64'h2C0, 13'h1011, pattern(32'h5EED_0001), 2, 10, -1);
        send_read(64'h2C0, 13'h0011, 11);
        collect(-1, 0, 1'b0, 64'h0, 13'h0, 0);

        // Reset during beat 4 of a write to line 2: prior contents must survive.
        do_write(64'h80, 13'h1002, pattern(32'hDEAD_0002), -1, 0, 4);
        @(negedge clk);
        send_read(64'h80, 13'h0002, 2);
        collect(-1, 0, 1'b0, 64'h0, 13'h0, 0);

        // New request raised while responding is held off until IDLE.
        send_read(64'h40, 13'h0111, 1);
        collect(-1, 0, 1'b1, 64'hFC0, 13'h0222, 63);
        wait_ack("busy_accept");
        bus_reqcyc = 1'b0;
        collect(-1, 0, 1'b0, 64'h0, 13'h0, 0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
